// File: rtl/pio_pkg.sv
// Shared types and constants for the PIO initiator and its responders.
package pio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } pio_state_e;

    localparam logic PIO_WRITE = 1'b1;
    localparam logic PIO_READ  = 1'b0;

    localparam int PIO_ADDR_W = 32;
    localparam int PIO_DATA_W = 32;

endpackage

// File: rtl/pio_master.sv
// PIO initiator: turns one host request at a time into a PIO command strobe,
// collects read data or times out, and returns one response per request.
module pio_master
    import pio_pkg::*;
#(
    parameter int ADDR_W      = PIO_ADDR_W,
    parameter int DATA_W      = PIO_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic              rsp_rw,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              pio_cmd_vld,
    output logic              pio_rw,
    output logic [ADDR_W-1:0] pio_addr,
    output logic [DATA_W-1:0] pio_data_w,
    input  logic [DATA_W-1:0] pio_data_r,
    input  logic              pio_rd_vld,
    output logic [7:0]        stray_cnt
);

    // Counter value seen in the last WAIT_RD cycle a read is allowed.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    pio_state_e state;
    logic [7:0] tmo_cnt;

    // NOTE: every register here uses <= so all updates in one edge see the
    // pre-edge values; mixing in = would make results depend on statement order.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous, so it only acts on a clock edge and
        // the reset cycle itself still shows the pre-reset register values.
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            req_rdy     <= 1'b0;
            rsp_vld     <= 1'b0;
            rsp_rw      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            pio_cmd_vld <= 1'b0;
            pio_rw      <= 1'b0;
            pio_addr    <= '0;
            pio_data_w  <= '0;
            stray_cnt   <= '0;
        end else begin
            // Read-valid outside WAIT_RD carries no data we asked for.
            if (pio_rd_vld && state != WAIT_RD && stray_cnt != 8'hFF)
                stray_cnt <= stray_cnt + 8'd1;

            case (state)
                IDLE: begin
                    req_rdy <= 1'b1;
                    if (req_vld && req_rdy) begin
                        req_rdy     <= 1'b0;
                        pio_cmd_vld <= 1'b1;
                        pio_rw      <= req_rw;
                        pio_addr    <= req_addr;
                        pio_data_w  <= req_wdata;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    pio_cmd_vld <= 1'b0;
                    rsp_rw      <= pio_rw;
                    tmo_cnt     <= '0;
                    if (pio_rw == PIO_WRITE) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        rsp_vld   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    if (pio_rd_vld) begin
                        rsp_rdata <= pio_data_r;
                        rsp_err   <= 1'b0;
                        rsp_vld   <= 1'b1;
                        state     <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_vld   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        req_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pio_master.md
Name: pio_master

Overview:
- PIO initiator: drives the PIO command bus (cmd_vld/rw/addr/data_w) toward register/table responders and collects read data (rd_vld/data_r).
- Accepts one host request at a time over a valid/ready port and returns one response per request over a valid/ready port.
- Detects read timeouts and counts stray read-valid pulses.
- Sits between the CSR host/test driver and the per-block PIO responders.

Parameters:
- ADDR_W, 32, PIO address width.
- DATA_W, 32, PIO data width.
- TIMEOUT_CYC, 16, maximum WAIT_RD cycles before a read is errored; legal range 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_vld  in  1  host request valid.
- req_rdy  out  1  host request ready.
- req_rw  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_rw  out  1  echo of the request rw.
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts).
- rsp_err  out  1  1 = read timeout.
- pio_cmd_vld  out  1  PIO command strobe.
- pio_rw  out  1  PIO direction, 1=write.
- pio_addr  out  ADDR_W  PIO address.
- pio_data_w  out  DATA_W  PIO write data.
- pio_data_r  in  DATA_W  PIO read data.
- pio_rd_vld  in  1  PIO read data valid.
- stray_cnt  out  8  saturating count of unexpected pio_rd_vld pulses.

Behaviour:
- All outputs are registered. On reset: state=IDLE; req_rdy=0 in the reset cycle, then 1; all other outputs are 0, including the pio_* outputs and stray_cnt.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - req_rdy=1.
  - On req_vld&&req_rdy, latch rw/addr/wdata and go to ISSUE; req_rdy drops the next cycle.
- ISSUE:
  - pio_cmd_vld=1 for exactly one cycle, with pio_rw/pio_addr/pio_data_w = latched values.
  - If rw=1, go to RESP with rsp_err=0 and rsp_rdata=0.
  - If rw=0, go to WAIT_RD and clear the timeout counter.
- WAIT_RD:
  - If pio_rd_vld=1, capture pio_data_r into rsp_rdata, set rsp_err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC with no rd_vld, set rsp_err=1 and rsp_rdata=0, and go to RESP.
  - A rd_vld in the final allowed cycle wins over the timeout.
- RESP:
  - rsp_vld=1; rsp_rw/rsp_rdata/rsp_err stay stable until rsp_rdy.
  - On rsp_vld&&rsp_rdy, go to IDLE and drop rsp_vld the next cycle.
- Latency: request accepted at edge T, pio_cmd_vld high in T+1.
  - Write: rsp_vld high in T+2.
  - Read with a 1-cycle responder: rd_vld high in T+2, rsp_vld high in T+3.
- pio_rw/pio_addr/pio_data_w hold their last value when pio_cmd_vld=0.
- Stray rd_vld: pio_rd_vld=1 in any state other than WAIT_RD (including the ISSUE cycle) is ignored for data and increments stray_cnt. stray_cnt saturates at 255 and is cleared only by reset.
- Back-pressure: rsp_rdy low holds RESP indefinitely; no new request is accepted until the response is consumed.
- Reset mid-operation: any in-flight transaction is dropped, no response is produced, and state returns to IDLE. A late rd_vld arriving after reset counts as stray.

Decomposition:
- Shared package pio_pkg holds:
  - pio_state_e enum {IDLE, ISSUE, WAIT_RD, RESP}.
  - Constants PIO_WRITE=1'b1 and PIO_READ=1'b0.
  - Default width constants PIO_ADDR_W=32 and PIO_DATA_W=32.
- No sub-module; the timeout counter and saturating stray counter are inline.

Test Plan:
- Write 0xCAFE_F00D to addr 0x1000 -> pio_cmd_vld=1, pio_rw=1 for one cycle in T+1; rsp_vld in T+2 with rsp_err=0, rsp_rdata=0.
- Read addr 0x0005 from a 1-cycle responder returning 0x1234_5678 -> rsp_vld in T+3, rsp_rdata=0x1234_5678, rsp_err=0.
- Read with a silent responder, TIMEOUT_CYC=16 -> exactly 16 WAIT_RD cycles, then rsp_vld=1, rsp_err=1, rsp_rdata=0. A second run with rd_vld on the 16th WAIT cycle -> rsp_err=0 with the captured data.
- Hold rsp_rdy=0 for 10 cycles after a read completes, with req_vld held high -> rsp fields stable, req_rdy=0 throughout; the next request is accepted only after the handshake.
- 300 rd_vld pulses while IDLE -> stray_cnt=255 (saturated); a subsequent normal read is unaffected.
- Assert reset during WAIT_RD -> no rsp_vld; all outputs 0; a rd_vld the cycle after reset deasserts gives stray_cnt=1.
